// File: rtl/keypad_scan_fifo_pkg.sv
// Shared definitions for the keypad scanner: 4x4 key indices, function codes,
// scan FSM states and a width helper.
package keypad_pkg;

  // $clog2 that never returns 0, so 1-entry ranges still get a 1-bit signal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Key indices (row*4 + col) for the common 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D pad.
  localparam int unsigned Key1    = 0,  Key2 = 1,  Key3    = 2,  KeyA = 3;
  localparam int unsigned Key4    = 4,  Key5 = 5,  Key6    = 6,  KeyB = 7;
  localparam int unsigned Key7    = 8,  Key8 = 9,  Key9    = 10, KeyC = 11;
  localparam int unsigned KeyStar = 12, Key0 = 13, KeyHash = 14, KeyD = 15;

  // Function codes produced by the downstream encoder for the non-digit keys.
  localparam logic [3:0] FnEnter     = 4'hA;
  localparam logic [3:0] FnResvA     = 4'hB;
  localparam logic [3:0] FnResvB     = 4'hC;
  localparam logic [3:0] FnBackspace = 4'hD;
  localparam logic [3:0] FnForward   = 4'hE;
  localparam logic [3:0] FnClear     = 4'hF;

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} scan_state_e;

endpackage

// File: rtl/keypad_scan_fifo_if.sv
// Key event stream: FIFO head with valid/ready handshake.
interface keypad_scan_fifo_if #(
  parameter int unsigned KW = 4
) ();
  logic [KW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_fifo_event_fifo.sv
// Small synchronous FIFO for key events: valid/ready pop side, push with
// full/drop reporting. Drop means a push arrived while full with no pop.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             drop
);
  localparam int unsigned PtrW = clog2_min1(Depth);
  localparam int unsigned CntW = clog2_min1(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             pop, accept;

  assign pop_valid = (cnt_q != '0);
  assign full      = (cnt_q == CntW'(Depth));
  assign pop       = pop_valid && pop_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign pop_data  = mem_q[rd_q];

  // Storage, pointers (wrap naturally, Depth is a power of 2) and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (accept && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!accept && pop) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with debounced press/release and a key event FIFO.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_DIV        = 6250000,
  parameter int unsigned DEBOUNCE_CYCLES = 30,
  parameter int unsigned FIFO_DEPTH      = 4,
`ifdef KEYPAD_REPEAT_EN
  parameter int unsigned REPEAT_DELAY    = 100,
  parameter int unsigned REPEAT_RATE     = 20,
`endif
  parameter int unsigned KW              = $clog2(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLS-1:0]      col_in,
  output logic [ROWS-1:0]      row_out,
  keypad_scan_fifo_if.master   key_if,
  output logic                 key_pressed,
  output logic                 overflow,
  input  logic                 ovf_clr
);
  localparam int unsigned RW = clog2_min1(ROWS);
  localparam int unsigned CW = clog2_min1(COLS);
  localparam int unsigned DW = clog2_min1(SCAN_DIV);
  localparam int unsigned BW = clog2_min1(DEBOUNCE_CYCLES);

  logic [COLS-1:0] col_meta_q, col_sync_q, pat_q, pat_d;
  logic [DW-1:0]   div_q;
  logic [RW-1:0]   row_q, row_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   col_idx;
  logic [KW-1:0]   push_code;
  scan_state_e     state_q, state_d;
  logic            tick, all_ones, pressed_q, pressed_d, ev_push, push, drop, fifo_full;

  // Two-flop synchroniser; idle (all released) is all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  assign all_ones = &col_sync_q;
  assign tick     = (div_q == DW'(SCAN_DIV - 1));

  // Free-running row-step divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Lowest-index low column of the latched pattern wins.
  always_comb begin
    col_idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!pat_q[i]) col_idx = CW'(i);
    end
  end

  assign push_code = KW'(int'(row_q) * int'(COLS) + int'(col_idx));

  // Scan FSM next state. cnt counts stable press cycles in DEBOUNCE and
  // consecutive released cycles in HELD.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    ev_push   = 1'b0;
    unique case (state_q)
      StScan: begin
        if (!all_ones) begin
          state_d = StDebounce;
          pat_d   = col_sync_q;
          cnt_d   = '0;
        end else if (tick) begin
          row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end
      end
      StDebounce: begin
        // Pattern is never all ones here, so this also catches a release.
        if (col_sync_q != pat_q) begin
          state_d = StScan;
          cnt_d   = '0;
        end else if (cnt_q == BW'(DEBOUNCE_CYCLES - 1)) begin
          state_d   = StHeld;
          cnt_d     = '0;
          pressed_d = 1'b1;
          ev_push   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!all_ones) begin
          cnt_d = '0;
        end else if (cnt_q == BW'(DEBOUNCE_CYCLES - 1)) begin
          state_d   = StScan;
          cnt_d     = '0;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StScan;
    endcase
  end

  // Scan FSM registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StScan;
      row_q     <= '0;
      pat_q     <= '1;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = clog2_min1(RepMax + 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_limit;
  logic            rep_first_q, rep_first_d, rep_push;

  // Repeat timer in divider ticks: first interval REPEAT_DELAY, then REPEAT_RATE.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_push    = 1'b0;
    rep_limit   = rep_first_q ? RepW'(REPEAT_DELAY - 1) : RepW'(REPEAT_RATE - 1);
    if (state_q != StHeld || all_ones) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (tick) begin
      if (rep_cnt_q == rep_limit) begin
        rep_push    = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign push = ev_push | rep_push;
`else
  assign push = ev_push;
`endif

  keypad_event_fifo #(
    .Width (KW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_code),
    .pop_ready (key_if.key_ready),
    .pop_valid (key_if.key_valid),
    .pop_data  (key_if.key_code),
    .full      (fifo_full),
    .drop      (drop)
  );

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  assert property (@(posedge clk) disable iff (!rst) drop |-> fifo_full);

  assign row_out     = ~(ROWS'(1) << row_q);
  assign key_pressed = pressed_q;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: a keypad matrix model driven from row_out, a
// queue model of the event buffer, directed scenarios plus randomized presses.
module tb_keypad_scan_fifo;
  localparam int unsigned ROWS = 4, COLS = 4, SDIV = 4, DEB = 5, DEPTH = 2, KW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic            key_pressed, overflow;
  logic            ovf_clr = 1'b0;

  keypad_scan_fifo_if #(.KW(KW)) kif ();

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH(DEPTH), .KW(KW)
  ) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out), .key_if(kif.master),
    .key_pressed(key_pressed), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its column low while its row is driven low.
  logic [COLS-1:0] held [ROWS];
  bit              bounce_en = 1'b0;
  logic [COLS-1:0] bounce_val = '1;
  always_comb begin
    col_in = '1;
    if (bounce_en) col_in = bounce_val;
    else for (int r = 0; r < ROWS; r++) if (!row_out[r]) col_in = col_in & ~held[r];
  end

  int total = 0, bad = 0;
  int exp_q[$];
  bit exp_ovf = 1'b0;

  function automatic int key_of(input int r, input logic [COLS-1:0] mask);
    for (int c = 0; c < COLS; c++) if (mask[c]) return r * COLS + c;
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_row(input int r, input bit active, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * ROWS * SDIV; i++) begin
      if ((row_out[r] == 1'b0) == active) begin ok = 1'b1; break; end
      step(1);
    end
  endtask

  // Press keys of one row just as that row becomes driven.
  task automatic arm_keys(input int r, input logic [COLS-1:0] mask, output bit ok);
    bit ok1, ok2;
    wait_row(r, 1'b0, ok1);
    held[r] = mask;
    wait_row(r, 1'b1, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic wait_pressed(input logic level, output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (key_pressed === level) begin ok = 1'b1; break; end
      step(1); n++;
    end
  endtask

  task automatic full_press(input int r, input logic [COLS-1:0] mask, output bit ok);
    bit o1, o2, o3; int n;
    arm_keys(r, mask, o1);
    wait_pressed(1'b1, n, o2);
    held[r] = '0;
    wait_pressed(1'b0, n, o3);
    ok = o1 && o2 && o3;
  endtask

  task automatic test_reset();
    logic [ROWS-1:0] exp_row;
    step(2);
    total++; if (row_out !== 4'b1110) begin bad++; $display("FAIL rst_row got=%b want=1110", row_out); end
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", kif.key_valid); end
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL rst_pressed got=%b want=0", key_pressed); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", overflow); end
    total++; if (kif.key_code !== '0) begin bad++; $display("FAIL rst_code got=%0d want=0", kif.key_code); end
    rst = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step(1);
      exp_row = '1;
      exp_row[(e / SDIV) % ROWS] = 1'b0;
      total++;
      if (row_out !== exp_row) begin bad++; $display("FAIL scan_row e=%0d got=%b want=%b", e, row_out, exp_row); end
    end
  endtask

  task automatic test_single_press();
    bit ok, frozen; int n;
    arm_keys(2, 4'b0010, ok);
    n = 0;
    for (int i = 0; i < 30 && kif.key_valid !== 1'b1; i++) begin step(1); n++; end
    total++; if (!ok || n != 2 + DEB + 1) begin bad++; $display("FAIL press_latency got=%0d want=%0d", n, 2 + DEB + 1); end
    total++; if (kif.key_code !== KW'(2 * COLS + 1)) begin bad++; $display("FAIL press_code got=%0d want=%0d", kif.key_code, 2 * COLS + 1); end
    total++; if (key_pressed !== 1'b1) begin bad++; $display("FAIL press_level got=%b want=1", key_pressed); end
    frozen = 1'b1;
    for (int i = 0; i < 10; i++) begin step(1); if (row_out !== 4'b1011) frozen = 1'b0; end
    total++; if (!frozen) begin bad++; $display("FAIL held_row_frozen got=%b want=1011", row_out); end
    held[2] = '0;
    wait_pressed(1'b0, n, ok);
    total++; if (!ok || n != DEB + 2) begin bad++; $display("FAIL release_latency got=%0d want=%0d", n, DEB + 2); end
    total++; if (kif.key_valid !== 1'b1) begin bad++; $display("FAIL valid_hold got=%b want=1", kif.key_valid); end
    kif.key_ready = 1'b1; step(1); kif.key_ready = 1'b0;
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL pop_empty got=%b want=0", kif.key_valid); end
  endtask

  task automatic test_bounce();
    bit ok; logic [ROWS-1:0] r0;
    bit lows [7] = '{1, 1, 1, 0, 1, 1, 1};
    wait_row(0, 1'b0, ok);
    wait_row(0, 1'b1, ok);
    bounce_en = 1'b1;
    foreach (lows[i]) begin bounce_val = lows[i] ? 4'b1110 : 4'b1111; step(1); end
    bounce_val = '1;
    step(20);
    bounce_en = 1'b0;
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL bounce_valid got=%b want=0", kif.key_valid); end
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL bounce_pressed got=%b want=0", key_pressed); end
    r0 = row_out;
    step(SDIV);
    total++; if (row_out === r0 || $countones(~row_out) != 1) begin bad++; $display("FAIL bounce_rescan got=%b want=advanced from %b", row_out, r0); end
  endtask

  task automatic test_overflow();
    bit ok, all_ok = 1'b1;
    kif.key_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      full_press(0, COLS'(1 << k), ok);
      all_ok &= ok;
      if (exp_q.size() < DEPTH) exp_q.push_back(k); else exp_ovf = 1'b1;
    end
    total++; if (!all_ok) begin bad++; $display("FAIL ovf_presses got=timeout want=complete"); end
    total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL ovf_set got=%b want=%b", overflow, exp_ovf); end
    while (exp_q.size() > 0) begin
      total++;
      if (kif.key_valid !== 1'b1 || kif.key_code !== KW'(exp_q[0])) begin
        bad++; $display("FAIL ovf_drain got=%b/%0d want=1/%0d", kif.key_valid, kif.key_code, exp_q[0]);
      end
      void'(exp_q.pop_front());
      kif.key_ready = 1'b1; step(1); kif.key_ready = 1'b0;
    end
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", kif.key_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0; exp_ovf = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", overflow); end
  endtask

  // Full FIFO: the third push lands in the same cycle as a pop.
  task automatic test_back_to_back();
    bit ok1, ok2, ok3; int n;
    kif.key_ready = 1'b0;
    full_press(1, 4'b0001, ok1); exp_q.push_back(4);
    full_press(1, 4'b1000, ok2); exp_q.push_back(7);
    arm_keys(3, 4'b0100, ok3);
    step(DEB + 2);
    total++; if (!(ok1 && ok2 && ok3) || key_pressed !== 1'b0) begin bad++; $display("FAIL b2b_setup got=%b want=0", key_pressed); end
    kif.key_ready = 1'b1; step(1); kif.key_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(14);
    total++; if (key_pressed !== 1'b1) begin bad++; $display("FAIL b2b_push got=%b want=1", key_pressed); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b want=0", overflow); end
    held[3] = '0;
    wait_pressed(1'b0, n, ok1);
    while (exp_q.size() > 0) begin
      total++;
      if (kif.key_valid !== 1'b1 || kif.key_code !== KW'(exp_q[0])) begin
        bad++; $display("FAIL b2b_order got=%b/%0d want=1/%0d", kif.key_valid, kif.key_code, exp_q[0]);
      end
      void'(exp_q.pop_front());
      kif.key_ready = 1'b1; step(1); kif.key_ready = 1'b0;
    end
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", kif.key_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok; int n;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        arm_keys(2, 4'b0010, ok);
        step(4);
        total++; if (!ok || row_out !== 4'b1011) begin bad++; $display("FAIL mid_debounce_row got=%b want=1011", row_out); end
      end else begin
        arm_keys(1, 4'b0100, ok);
        wait_pressed(1'b1, n, ok);
        total++; if (!ok || kif.key_valid !== 1'b1) begin bad++; $display("FAIL mid_held_valid got=%b want=1", kif.key_valid); end
      end
      #2 rst = 1'b0;
      #1;
      total++; if (row_out !== 4'b1110) begin bad++; $display("FAIL mid_rst_row p=%0d got=%b want=1110", phase, row_out); end
      total++; if (kif.key_valid !== 1'b0 || key_pressed !== 1'b0 || overflow !== 1'b0 || kif.key_code !== '0) begin
        bad++; $display("FAIL mid_rst_outs p=%0d got=%b%b%b/%0d want=000/0", phase, kif.key_valid, key_pressed, overflow, kif.key_code);
      end
      for (int r = 0; r < ROWS; r++) held[r] = '0;
      @(posedge clk); #1 rst = 1'b1;
    end
    exp_q.delete();
    full_press(0, 4'b1000, ok);
    total++; if (!ok || kif.key_valid !== 1'b1 || kif.key_code !== KW'(3)) begin
      bad++; $display("FAIL post_rst_press got=%b/%0d want=1/3", kif.key_valid, kif.key_code);
    end
    kif.key_ready = 1'b1; step(1); kif.key_ready = 1'b0;
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL post_rst_empty got=%b want=0", kif.key_valid); end
  endtask

  task automatic test_random();
    bit ok; int n, r; logic [COLS-1:0] mask;
    for (int round = 0; round < 6; round++) begin
      kif.key_ready = 1'b0;
      n = $urandom_range(1, 4);
      for (int p = 0; p < n; p++) begin
        r = $urandom_range(0, ROWS - 1);
        mask = COLS'($urandom_range(1, (1 << COLS) - 1));
        full_press(r, mask, ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_press r=%0d m=%b got=timeout want=complete", r, mask); end
        if (exp_q.size() < DEPTH) exp_q.push_back(key_of(r, mask)); else exp_ovf = 1'b1;
      end
      total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL rnd_ovf got=%b want=%b", overflow, exp_ovf); end
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
        kif.key_ready = 1'($urandom_range(0, 1));
        if (kif.key_ready && kif.key_valid) begin
          total++;
          if (kif.key_code !== KW'(exp_q[0])) begin bad++; $display("FAIL rnd_code got=%0d want=%0d", kif.key_code, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        step(1);
      end
      kif.key_ready = 1'b0;
      total++; if (kif.key_valid !== 1'b0 || exp_q.size() != 0) begin
        bad++; $display("FAIL rnd_drain got=%b/%0d want=0/0", kif.key_valid, exp_q.size());
      end
      ovf_clr = 1'b1; step(1); ovf_clr = 1'b0; exp_ovf = 1'b0;
    end
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) held[r] = '0;
    kif.key_ready = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
